multicycle_computer: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle computer. It runs the same A/B accumulator instruction style (7-bit opcode plus DATA_W-bit literal).
- Execution is sequenced by an FSM: FETCH, EXEC, MEM_WAIT, HALT.
- Adds a handshaked data-memory port, so wait-state RAM or peripherals can sit behind it.
- Adds CALL/RET on an internal return stack, HALT, and sticky error reporting.
- Instantiated at top level with instruction ROM and data memory outside the core.

---
 rtl/multicycle_computer.sv | 147 ++++++++++++++
 tb/tb_multicycle_computer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_computer.sv
// multicycle_computer: FSM-sequenced A/B accumulator core with a handshaked data port,
// a return stack for CALL/RET, and sticky error reporting.
module multicycle_computer #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W+6:0] imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [3:0]        flags,
    output logic              halted,
    output logic [1:0]        err
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM_WAIT, HALT} state_t;
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    state_t            r_state;
    logic [DATA_W+6:0] r_ir;
    logic [ADDR_W-1:0] r_pc, r_daddr;
    logic [DATA_W-1:0] r_a, r_b;
    logic [3:0]        r_flags;
    logic [1:0]        r_err;
    logic [SP_W-1:0]   r_sp;
    logic              r_req, r_we;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic [6:0]        w_op;
    logic [DATA_W-1:0] w_lit, w_opnd, w_res;
    logic [DATA_W:0]   w_sum;
    logic [SP_W-2:0]   w_top;
    logic              w_sub, w_logic, w_alu, w_mem, w_legal, w_jump, w_c, w_v;
    logic              w_full, w_empty, w_push;

    always_comb begin
        w_op    = r_ir[DATA_W+6:DATA_W];
        w_lit   = r_ir[DATA_W-1:0];
        w_opnd  = (w_op == 7'h0C || w_op == 7'h0D) ? w_lit : r_b;
        w_sub   = w_op == 7'h06 || w_op == 7'h0D || w_op == 7'h10;
        w_logic = w_op == 7'h08 || w_op == 7'h09 || w_op == 7'h0A;
        w_alu   = w_sub || w_logic || w_op == 7'h04 || w_op == 7'h0C;
        w_mem   = w_op inside {7'h20, 7'h21, 7'h22, 7'h23};
        w_legal = w_alu || w_mem || w_op inside {7'h00, 7'h02, 7'h03, 7'h30, 7'h31, 7'h32,
                                                 7'h33, 7'h38, 7'h39, 7'h7F};
        // The extra top bit is carry for add and borrow (A < operand) for subtract.
        w_sum   = w_sub ? {1'b0, r_a} - {1'b0, w_opnd} : {1'b0, r_a} + {1'b0, w_opnd};
        w_res   = w_op == 7'h08 ? r_a & r_b : w_op == 7'h09 ? r_a | r_b :
                  w_op == 7'h0A ? r_a ^ r_b : w_sum[DATA_W-1:0];
        w_c     = !w_logic && w_sum[DATA_W];
        w_v     = !w_logic && (w_res[DATA_W-1] != r_a[DATA_W-1]) &&
                  ((r_a[DATA_W-1] != w_opnd[DATA_W-1]) == w_sub);
        w_jump  = w_op == 7'h30 || (w_op == 7'h31 && r_flags[3]) ||
                  (w_op == 7'h32 && !r_flags[3]) || (w_op == 7'h33 && r_flags[1]);
        w_full  = r_sp == SP_W'(STACK_DEPTH);
        w_empty = r_sp == '0;
        w_top   = r_sp[SP_W-2:0] - 1'b1;
        w_push  = r_state == EXEC && w_op == 7'h38 && !w_full;
    end

    always_ff @(posedge clk)
        if (w_push) r_stack[r_sp[SP_W-2:0]] <= r_pc + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
            r_ir    <= '0;
            r_pc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_flags <= '0;
            r_err   <= '0;
            r_sp    <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_daddr <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    r_ir    <= imem_data;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_state <= FETCH;
                    r_pc    <= r_pc + 1'b1;
                    if (w_alu) r_flags <= {w_res == '0, w_res[DATA_W-1], w_c, w_v};
                    if (w_alu && w_op != 7'h10) r_a <= w_res;
                    if (w_op == 7'h02) r_a <= w_lit;
                    if (w_op == 7'h03) r_b <= w_lit;
                    if (!w_legal) r_err[0] <= 1'b1;
                    if (w_jump) r_pc <= w_lit[ADDR_W-1:0];
                    if (w_mem) begin
                        r_state <= MEM_WAIT;
                        r_pc    <= r_pc;
                        r_req   <= 1'b1;
                        r_we    <= w_op[0];
                        r_daddr <= w_op[1] ? r_b[ADDR_W-1:0] : w_lit[ADDR_W-1:0];
                    end
                    if (w_op == 7'h38) begin
                        r_pc <= w_full ? r_pc : w_lit[ADDR_W-1:0];
                        r_sp <= w_full ? r_sp : r_sp + 1'b1;
                    end
                    if (w_op == 7'h39) begin
                        r_pc <= w_empty ? r_pc : r_stack[w_top];
                        r_sp <= w_empty ? r_sp : r_sp - 1'b1;
                    end
                    if ((w_op == 7'h38 && w_full) || (w_op == 7'h39 && w_empty)) begin
                        r_err[1] <= 1'b1;
                        r_state  <= HALT;
                    end
                    if (w_op == 7'h7F) begin
                        r_pc    <= r_pc;
                        r_state <= HALT;
                    end
                end
                MEM_WAIT: if (dmem_ack) begin
                    r_req   <= 1'b0;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= FETCH;
                    if (!r_we) r_a <= dmem_rdata;
                end
                default: r_state <= HALT;
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign pc_out     = r_pc;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_daddr;
    assign dmem_wdata = r_a;
    assign reg_a      = r_a;
    assign reg_b      = r_b;
    assign flags      = r_flags;
    assign err        = r_err;
    assign halted     = r_state == HALT;
endmodule

// File: tb/tb_multicycle_computer.sv
// tb_multicycle_computer: directed vectors for the 8-bit core plus a 16/10-bit instance
// exercising wide arithmetic and PC wrap.
module tb_multicycle_computer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [14:0] rom [256];
    logic [7:0]  mem [256];
    logic [7:0]  imem_addr, dmem_addr, pc_out, reg_a, reg_b, dmem_wdata, dmem_rdata;
    logic        dmem_req, dmem_we, dmem_ack, halted;
    logic [3:0]  flags;
    logic [1:0]  err;

    assign dmem_rdata = mem[dmem_addr];
    always @(posedge clk) if (dmem_req && dmem_ack && dmem_we) mem[dmem_addr] <= dmem_wdata;

    multicycle_computer u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(rom[imem_addr]),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .pc_out(pc_out), .reg_a(reg_a),
        .reg_b(reg_b), .flags(flags), .halted(halted), .err(err)
    );

    logic [22:0] rom16 [1024];
    logic [9:0]  w_iaddr16, w_daddr16, w_pc16;
    logic [15:0] w_wdata16, w_a16, w_b16;
    logic        w_req16, w_we16, w_halted16;
    logic [3:0]  w_flags16;
    logic [1:0]  w_err16;

    multicycle_computer #(.DATA_W(16), .ADDR_W(10), .STACK_DEPTH(4)) u_dut16 (
        .clk(clk), .rst(rst), .imem_addr(w_iaddr16), .imem_data(rom16[w_iaddr16]),
        .dmem_req(w_req16), .dmem_we(w_we16), .dmem_addr(w_daddr16), .dmem_wdata(w_wdata16),
        .dmem_rdata(16'h0000), .dmem_ack(1'b0), .pc_out(w_pc16), .reg_a(w_a16),
        .reg_b(w_b16), .flags(w_flags16), .halted(w_halted16), .err(w_err16)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 256; i++) rom[i] = 15'h0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [7:0] lit;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
        logic [1:0] e;
    } vec_t;

    vec_t vec [16];

    initial begin
        vec[0]  = '{7'h02, 8'h05, 8'h05, 8'h00, 4'h0, 2'd0};
        vec[1]  = '{7'h03, 8'h03, 8'h05, 8'h03, 4'h0, 2'd0};
        vec[2]  = '{7'h04, 8'h00, 8'h08, 8'h03, 4'h0, 2'd0};
        vec[3]  = '{7'h02, 8'h7F, 8'h7F, 8'h03, 4'h0, 2'd0};
        vec[4]  = '{7'h0C, 8'h01, 8'h80, 8'h03, 4'h5, 2'd0};
        vec[5]  = '{7'h02, 8'h10, 8'h10, 8'h03, 4'h5, 2'd0};
        vec[6]  = '{7'h03, 8'h20, 8'h10, 8'h20, 4'h5, 2'd0};
        vec[7]  = '{7'h10, 8'h00, 8'h10, 8'h20, 4'h6, 2'd0};
        vec[8]  = '{7'h06, 8'h00, 8'hF0, 8'h20, 4'h6, 2'd0};
        vec[9]  = '{7'h08, 8'h00, 8'h20, 8'h20, 4'h0, 2'd0};
        vec[10] = '{7'h09, 8'h00, 8'h20, 8'h20, 4'h0, 2'd0};
        vec[11] = '{7'h0A, 8'h00, 8'h00, 8'h20, 4'h8, 2'd0};
        vec[12] = '{7'h0D, 8'h01, 8'hFF, 8'h20, 4'h6, 2'd0};
        vec[13] = '{7'h0C, 8'h01, 8'h00, 8'h20, 4'hA, 2'd0};
        vec[14] = '{7'h55, 8'h00, 8'h00, 8'h20, 4'hA, 2'd1};
        vec[15] = '{7'h00, 8'h00, 8'h00, 8'h20, 4'hA, 2'd1};
        dmem_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) rom16[i] = 23'h0;

        clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = {vec[i].op, vec[i].lit};
        do_reset();
        chk("reset_pc", pc_out, 0);
        chk("reset_a", reg_a, 0);
        chk("reset_flags", flags, 0);
        chk("reset_req", dmem_req, 0);
        chk("reset_halted", halted, 0);
        for (int i = 0; i < 16; i++) begin
            step(2);
            chk($sformatf("v%0d_pc", i), pc_out, i + 1);
            chk($sformatf("v%0d_a", i), reg_a, vec[i].a);
            chk($sformatf("v%0d_b", i), reg_b, vec[i].b);
            chk($sformatf("v%0d_flags", i), flags, vec[i].f);
            chk($sformatf("v%0d_err", i), err, vec[i].e);
        end

        // store with 3 wait cycles, then zero-wait load of the same location
        clear_rom();
        rom[0] = {7'h02, 8'hAB};
        rom[1] = {7'h21, 8'h40};
        rom[2] = {7'h02, 8'h00};
        rom[3] = {7'h20, 8'h40};
        rom[4] = {7'h7F, 8'h00};
        do_reset();
        step(4);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("st_req%0d", k), dmem_req, 1);
            chk($sformatf("st_we%0d", k), dmem_we, 1);
            chk($sformatf("st_addr%0d", k), dmem_addr, 8'h40);
            chk($sformatf("st_wdata%0d", k), dmem_wdata, 8'hAB);
            chk($sformatf("st_pc%0d", k), pc_out, 1);
            step(1);
        end
        dmem_ack = 1'b1;
        step(1);
        dmem_ack = 1'b0;
        chk("st_req_drop", dmem_req, 0);
        chk("st_pc_after", pc_out, 2);
        chk("st_mem", mem[8'h40], 8'hAB);
        step(2);
        chk("ld_clear_a", reg_a, 0);
        step(2);
        chk("ld_req", dmem_req, 1);
        chk("ld_we", dmem_we, 0);
        dmem_ack = 1'b1;
        step(1);
        dmem_ack = 1'b0;
        chk("ld_a", reg_a, 8'hAB);
        chk("ld_pc", pc_out, 4);
        chk("ld_req_drop", dmem_req, 0);
        dmem_ack = 1'b1;
        step(2);
        dmem_ack = 1'b0;
        chk("halt_flag", halted, 1);
        chk("halt_stray_ack_a", reg_a, 8'hAB);
        step(4);
        chk("halt_pc", pc_out, 4);

        // CALL/RET
        clear_rom();
        rom[5]     = {7'h38, 8'h10};
        rom[6]     = {7'h7F, 8'h00};
        rom[8'h10] = {7'h39, 8'h00};
        do_reset();
        step(10);
        chk("call_pre_pc", pc_out, 5);
        step(2);
        chk("call_pc", pc_out, 8'h10);
        step(2);
        chk("ret_pc", pc_out, 6);
        chk("ret_err", err, 0);

        // nine nested CALLs overflow the 8-deep stack
        clear_rom();
        for (int i = 0; i < 9; i++) rom[i] = {7'h38, 8'(i + 1)};
        do_reset();
        step(16);
        chk("nest8_pc", pc_out, 8);
        chk("nest8_err", err, 0);
        step(2);
        chk("ovf_err", err, 2'b10);
        chk("ovf_halted", halted, 1);
        chk("ovf_pc", pc_out, 8);
        step(4);
        chk("ovf_pc_frozen", pc_out, 8);

        // RET on empty stack
        clear_rom();
        rom[0] = {7'h39, 8'h00};
        do_reset();
        step(2);
        chk("unf_err", err, 2'b10);
        chk("unf_halted", halted, 1);
        chk("unf_pc", pc_out, 0);

        // conditional jumps
        clear_rom();
        rom[0]     = {7'h02, 8'h01};
        rom[1]     = {7'h0D, 8'h01};
        rom[2]     = {7'h31, 8'h10};
        rom[8'h10] = {7'h32, 8'h20};
        rom[8'h11] = {7'h33, 8'h30};
        rom[8'h12] = {7'h30, 8'h05};
        do_reset();
        step(4);
        chk("jz_flags", flags, 4'h8);
        step(2);
        chk("jeq_taken", pc_out, 8'h10);
        step(2);
        chk("jne_untaken", pc_out, 8'h11);
        step(2);
        chk("jcs_untaken", pc_out, 8'h12);
        step(2);
        chk("jmp", pc_out, 8'h05);

        // illegal opcode then async reset during a pending store
        clear_rom();
        rom[0] = {7'h55, 8'h00};
        rom[1] = {7'h21, 8'h40};
        do_reset();
        step(2);
        chk("illegal_err", err, 2'b01);
        chk("illegal_pc", pc_out, 1);
        step(3);
        chk("pend_req", dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_req", dmem_req, 0);
        chk("async_pc", pc_out, 0);
        chk("async_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // 16-bit data, 10-bit address instance
        rom16[0]      = {7'h02, 16'hFFFF};
        rom16[1]      = {7'h0C, 16'h0001};
        rom16[2]      = {7'h30, 16'h03FF};
        rom16[10'h3FF] = {7'h00, 16'h0000};
        do_reset();
        step(4);
        chk("w16_a", w_a16, 0);
        chk("w16_flags", w_flags16, 4'hA);
        step(2);
        chk("w16_jmp", w_pc16, 10'h3FF);
        step(2);
        chk("w16_wrap", w_pc16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
